// File: rtl/quad_pkg.sv
// Shared types and helpers for the rotary-encoder quadrature decoder.
package quad_pkg;

    // Encoder position; the encoding is the filtered {A,B} vector itself.
    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S10 = 2'b10,
        S11 = 2'b11
    } ab_t;

    // Classification of one filtered transition.
    typedef enum logic [1:0] {
        NONE    = 2'd0,
        CW      = 2'd1,
        CCW     = 2'd2,
        ILLEGAL = 2'd3
    } dir_t;

    // Stability counter width; holds FILT_CYCLES up to 255.
    localparam int CNT_W = 8;

    // Signed sub-step accumulator width; holds +/-7 for up to 8 steps per detent.
    localparam int ACC_W = 4;

    // Clockwise order is S00 -> S10 -> S11 -> S01 -> S00 (A leads B).
    function automatic dir_t quad_dir(ab_t prev, ab_t cur);
        dir_t d;
        if (prev == cur) begin
            d = NONE;
        end else if ((prev ^ cur) == 2'b11) begin
            d = ILLEGAL;
        end else begin
            case (prev)
                S00:     d = (cur == S10) ? CW : CCW;
                S10:     d = (cur == S11) ? CW : CCW;
                S11:     d = (cur == S01) ? CW : CCW;
                default: d = (cur == S00) ? CW : CCW;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/sync_filter.sv
// Two-flop synchroniser plus stability filter for a small vector of slow,
// bouncy asynchronous inputs (encoder contacts, pushbuttons).
module sync_filter
    import quad_pkg::*;
#(
    parameter int WIDTH       = 2,
    parameter int FILT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             upd
);

    localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(FILT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept;

    // Count consecutive edges on which the second stage captures the same value.
    // The check looks at the value entering the second stage so that a level
    // captured at edge 0 is accepted exactly at edge FILT_CYCLES.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        cnt_nxt = cnt;
        if (sync1 != sync2) begin
            cnt_nxt = CNT_ONE;
        end else if (cnt != FILT_MAX) begin
            cnt_nxt = cnt + CNT_ONE;
        end
        accept = (cnt_nxt == FILT_MAX) && (sync1 != dout);
    end

    // Synchroniser, stability counter and filtered output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            cnt   <= '0;
            dout  <= '0;
            upd   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let sync2 take the old sync1,
            // giving a true two-stage pipeline regardless of statement order.
            sync1 <= din;
            sync2 <= sync1;
            cnt   <= cnt_nxt;
            upd   <= accept;
            if (accept) begin
                dout <= sync1;
            end
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B Gray-code tracking, per-detent step pulse
// with held direction, and an error pulse on double-bit jumps.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int FILT_CYCLES      = 4,
    parameter int STEPS_PER_DETENT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic a,
    input  logic b,
    output logic step,
    output logic upDown,
    output logic err
);

    localparam logic signed [ACC_W-1:0] ACC_LIM = ACC_W'(STEPS_PER_DETENT - 1);
    localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);

    logic [1:0]              filt_ab;
    logic                    filt_upd;
    ab_t                     cur;
    ab_t                     state_q;
    ab_t                     state_d;
    logic                    init_q;
    logic                    init_d;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic                    step_d;
    logic                    err_d;
    logic                    updown_d;

    sync_filter #(
        .WIDTH       (2),
        .FILT_CYCLES (FILT_CYCLES)
    ) u_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .din     ({a, b}),
        .dout    (filt_ab),
        .upd     (filt_upd)
    );

    assign cur = ab_t'(filt_ab);

    // Evaluate each filtered update: first one after reset only loads the state.
    always_comb begin
        state_d  = state_q;
        init_d   = init_q;
        acc_d    = acc_q;
        step_d   = 1'b0;
        err_d    = 1'b0;
        updown_d = upDown;
        if (filt_upd) begin
            state_d = cur;
            if (init_q) begin
                init_d = 1'b0;
            end else begin
                unique case (quad_dir(state_q, cur))
                    NONE: ;
                    CW: begin
                        if (acc_q == ACC_LIM) begin
                            step_d   = 1'b1;
                            updown_d = 1'b1;
                            acc_d    = '0;
                        end else begin
                            acc_d = acc_q + ACC_ONE;
                        end
                    end
                    CCW: begin
                        if (acc_q == -ACC_LIM) begin
                            step_d   = 1'b1;
                            updown_d = 1'b0;
                            acc_d    = '0;
                        end else begin
                            acc_d = acc_q - ACC_ONE;
                        end
                    end
                    ILLEGAL: begin
                        err_d = 1'b1;
                        acc_d = '0;
                    end
                endcase
            end
        end
    end

    // State, init flag, accumulator and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S00;
            init_q  <= 1'b1;
            acc_q   <= '0;
            step    <= 1'b0;
            err     <= 1'b0;
            upDown  <= 1'b1;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            acc_q   <= acc_d;
            step    <= step_d;
            err     <= err_d;
            upDown  <= updown_d;
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed phases with literal pins plus
// randomized encoder motion, compared every cycle against a window-based model.
module tb_quad_decoder;

    localparam int FILT = 4;
    localparam int SPD  = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic a = 1'b0;
    logic b = 1'b0;
    logic step;
    logic upDown;
    logic err;

    int checks = 0;
    int errors = 0;

    quad_decoder #(
        .FILT_CYCLES      (FILT),
        .STEPS_PER_DETENT (SPD)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .a       (a),
        .b       (b),
        .step    (step),
        .upDown  (upDown),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Position around the clockwise ring 00 -> 10 -> 11 -> 01.
    function automatic int ring_pos(bit [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    bit [1:0] win [FILT];   // raw {a,b} captured on the last FILT edges
    bit [1:0] m_filt;
    bit [1:0] p_val;
    bit       m_pend;
    bit       m_init;
    bit [1:0] m_state;
    int       m_acc;
    bit       m_step;
    bit       m_err;
    bit       m_ud;
    int       cyc = 0;

    // Edge counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Model: accept a value seen on FILT consecutive captures, act on it one edge later.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FILT; i++) win[i] <= 2'b00;
            m_filt  <= 2'b00;
            p_val   <= 2'b00;
            m_pend  <= 1'b0;
            m_init  <= 1'b1;
            m_state <= 2'b00;
            m_acc   <= 0;
            m_step  <= 1'b0;
            m_err   <= 1'b0;
            m_ud    <= 1'b1;
        end else begin : model_step
            bit [1:0] nf;
            bit       np;
            bit       ni;
            bit [1:0] ns;
            int       na;
            bit       nst;
            bit       ner;
            bit       nud;
            bit       same;
            nf  = m_filt;
            np  = 1'b0;
            ni  = m_init;
            ns  = m_state;
            na  = m_acc;
            nst = 1'b0;
            ner = 1'b0;
            nud = m_ud;
            if (m_pend) begin
                if (ni) begin
                    ni = 1'b0;
                end else begin
                    case ((ring_pos(p_val) - ring_pos(m_state) + 4) % 4)
                        1: begin
                            na = na + 1;
                            if (na == SPD) begin nst = 1'b1; nud = 1'b1; na = 0; end
                        end
                        3: begin
                            na = na - 1;
                            if (na == -SPD) begin nst = 1'b1; nud = 1'b0; na = 0; end
                        end
                        2: begin ner = 1'b1; na = 0; end
                        default: ;
                    endcase
                end
                ns = p_val;
            end
            same = 1'b1;
            for (int i = 1; i < FILT; i++) if (win[i] != win[0]) same = 1'b0;
            if (same && (win[0] != m_filt)) begin
                nf = win[0];
                np = 1'b1;
            end
            for (int i = FILT - 1; i > 0; i--) win[i] <= win[i-1];
            win[0]  <= {a, b};
            m_filt  <= nf;
            p_val   <= nf;
            m_pend  <= np;
            m_init  <= ni;
            m_state <= ns;
            m_acc   <= na;
            m_step  <= nst;
            m_err   <= ner;
            m_ud    <= nud;
        end
    end

    // ---------------- compare process ----------------
    int n_step = 0;
    int n_err = 0;
    int n_step_dn = 0;
    int last_step_cyc = -1;
    bit prev_ev = 1'b0;

    // Compare outputs with the model on every falling edge and tally pulses.
    always @(negedge clk) begin
        check("step", step, m_step);
        check("err", err, m_err);
        check("upDown", upDown, m_ud);
        check("event_spacing", prev_ev & (step | err), 0);
        prev_ev <= step | err;
        if (step === 1'b1) begin
            n_step        <= n_step + 1;
            last_step_cyc <= cyc;
            if (upDown === 1'b0) n_step_dn <= n_step_dn + 1;
        end
        if (err === 1'b1) n_err <= n_err + 1;
    end

    // ---------------- stimulus ----------------
    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive(input bit [1:0] v, input int hold);
        a = v[1];
        b = v[0];
        wait_cycles(hold);
    endtask

    task automatic pulse_reset(input int n);
        reset_n = 1'b0;
        wait_cycles(n);
        reset_n = 1'b1;
    endtask

    int s0;
    int e0;
    int d0;
    int d_cyc;

    initial begin
        reset_n = 1'b0;
        a = 1'b1;
        b = 1'b1;
        wait_cycles(5);
        check("reset_step", step, 0);
        check("reset_err", err, 0);
        check("reset_updown", upDown, 1);
        reset_n = 1'b1;

        // Rest at 11 through and after reset: silent init load.
        s0 = n_step; e0 = n_err;
        wait_cycles(50);
        check("rest_steps", n_step - s0, 0);
        check("rest_errs", n_err - e0, 0);
        check("rest_updown", upDown, 1);

        // 11 -> 00 is a double-bit jump: one err, accumulator cleared.
        s0 = n_step; e0 = n_err;
        drive(2'b00, 10);
        check("jump_to_00_errs", n_err - e0, 1);
        check("jump_to_00_steps", n_step - s0, 0);

        // One clockwise detent.
        s0 = n_step; e0 = n_err;
        drive(2'b10, 10);
        drive(2'b11, 10);
        drive(2'b01, 10);
        d_cyc = cyc;
        drive(2'b00, 10);
        check("cw_steps", n_step - s0, 1);
        check("cw_errs", n_err - e0, 0);
        check("cw_updown", upDown, 1);
        check("cw_latency_edges", last_step_cyc - (d_cyc + 1), 5);

        // Two counter-clockwise detents.
        s0 = n_step; d0 = n_step_dn;
        for (int k = 0; k < 2; k++) begin
            drive(2'b01, 10);
            drive(2'b11, 10);
            drive(2'b10, 10);
            drive(2'b00, 10);
        end
        check("ccw_steps", n_step - s0, 2);
        check("ccw_steps_down", n_step_dn - d0, 2);
        wait_cycles(20);
        check("ccw_updown_held", upDown, 0);

        // Glitch on A shorter than the filter at rest 00.
        s0 = n_step; e0 = n_err;
        drive(2'b10, 3);
        drive(2'b00, 20);
        check("glitch_steps", n_step - s0, 0);
        check("glitch_errs", n_err - e0, 0);

        // Illegal 00 -> 11, then three clockwise moves: no detent.
        s0 = n_step; e0 = n_err;
        drive(2'b11, 10);
        check("illegal_errs", n_err - e0, 1);
        check("illegal_steps", n_step - s0, 0);
        s0 = n_step;
        drive(2'b01, 10);
        drive(2'b00, 10);
        drive(2'b10, 10);
        check("after_illegal_steps", n_step - s0, 0);

        // Clear the accumulator with a jump, then 3 CW and 3 CCW.
        e0 = n_err;
        drive(2'b01, 10);
        check("clear_jump_errs", n_err - e0, 1);
        s0 = n_step;
        drive(2'b00, 10);
        drive(2'b10, 10);
        drive(2'b11, 10);
        drive(2'b10, 10);
        drive(2'b00, 10);
        drive(2'b01, 10);
        check("reversal_steps", n_step - s0, 0);

        // Three CW, reset mid-detent, then one CW: partial detent discarded.
        s0 = n_step; e0 = n_err;
        drive(2'b00, 10);
        drive(2'b10, 10);
        drive(2'b11, 10);
        pulse_reset(2);
        check("midreset_updown", upDown, 1);
        drive(2'b11, 10);
        drive(2'b01, 10);
        check("midreset_steps", n_step - s0, 0);
        check("midreset_errs", n_err - e0, 0);

        // Randomized motion, bounces, jumps and occasional resets.
        for (int seg = 0; seg < 300; seg++) begin
            int       r;
            bit [1:0] cur;
            bit [1:0] flip;
            cur  = {a, b};
            r    = $urandom_range(0, 49);
            flip = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
            if (r == 0) begin
                pulse_reset($urandom_range(1, 3));
            end else if (r < 5) begin
                drive(cur ^ 2'b11, $urandom_range(1, 12));
            end else if (r < 12) begin
                drive(cur ^ flip, $urandom_range(1, FILT - 1));
                drive(cur, $urandom_range(1, 12));
            end else begin
                drive(cur ^ flip, $urandom_range(1, 12));
            end
        end
        wait_cycles(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
